// File: rtl/writeback_unit_pkg.sv
// Shared widths and the write-request record for the register-file writeback path.
// Optional result forwarding is enabled by defining WB_FWD_EN.
package wb_pkg;

  localparam int WbDataWidth  = 16;
  localparam int WbNumRegs    = 16;
  localparam int WbAddrWidth  = $clog2(WbNumRegs);
  localparam int WbLoadQDepth = 4;

  typedef struct packed {
    logic [WbAddrWidth-1:0] addr;
    logic [WbDataWidth-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/writeback_unit_if.sv
// Writeback bundle: issue reservation, ALU/load results, register-file write port and hazard checks.
// Forwarding outputs exist only when WB_FWD_EN is defined.
interface writeback_unit_if
  import wb_pkg::*;
#(
  parameter int DataWidth = WbDataWidth,
  parameter int AddrWidth = WbAddrWidth
);

  logic                 issue_valid;
  logic [AddrWidth-1:0] issue_addr;
  logic                 issue_stall;
  logic                 alu_valid;
  logic [AddrWidth-1:0] alu_addr;
  logic [DataWidth-1:0] alu_data;
  logic                 ld_valid;
  logic                 ld_ready;
  logic [AddrWidth-1:0] ld_addr;
  logic [DataWidth-1:0] ld_data;
  logic                 reg_w_en;
  logic [AddrWidth-1:0] addr_in;
  logic [DataWidth-1:0] reg_in;
  logic [AddrWidth-1:0] chk_addr1;
  logic [AddrWidth-1:0] chk_addr2;
  logic                 chk_busy1;
  logic                 chk_busy2;
`ifdef WB_FWD_EN
  logic                 fwd_hit1;
  logic                 fwd_hit2;
  logic [DataWidth-1:0] fwd_data1;
  logic [DataWidth-1:0] fwd_data2;
`endif

  modport master (
    output issue_valid, issue_addr, alu_valid, alu_addr, alu_data,
           ld_valid, ld_addr, ld_data, chk_addr1, chk_addr2,
`ifdef WB_FWD_EN
    input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
`endif
    input  issue_stall, ld_ready, reg_w_en, addr_in, reg_in, chk_busy1, chk_busy2
  );

  modport slave (
    input  issue_valid, issue_addr, alu_valid, alu_addr, alu_data,
           ld_valid, ld_addr, ld_data, chk_addr1, chk_addr2,
`ifdef WB_FWD_EN
    output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
`endif
    output issue_stall, ld_ready, reg_w_en, addr_in, reg_in, chk_busy1, chk_busy2
  );

endinterface

// File: rtl/writeback_unit_load_fifo.sv
// Small synchronous FIFO holding load results while the ALU owns the write port.
module wb_load_fifo
  import wb_pkg::*;
#(
  parameter int Depth = WbLoadQDepth
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output wb_req_t head
);

  localparam int PtrWidth = $clog2(Depth);
  localparam int CntWidth = PtrWidth + 1;

  wb_req_t               mem_q [Depth];
  wb_req_t               mem_d [Depth];
  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0]   count_q, count_d;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count_q == CntWidth'(Depth));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Power-of-two depth lets the pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PtrWidth'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrWidth'(1);
    end
    count_d = count_q + CntWidth'(do_push) - CntWidth'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write port arbiter (ALU over queued loads) with a per-register pending scoreboard.
// Define WB_FWD_EN to forward the value on the write port to the hazard-check outputs.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int DataWidth  = WbDataWidth,
  parameter int NumRegs    = WbNumRegs,
  parameter int AddrWidth  = $clog2(NumRegs),
  parameter int LoadQDepth = WbLoadQDepth
) (
  input  logic             clk,
  input  logic             rst_n,
  writeback_unit_if.slave  wb
);

  wb_req_t              ld_req;
  wb_req_t              fifo_head;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 issue_stall;
  logic                 reg_w_en_q, reg_w_en_d;
  logic [AddrWidth-1:0] addr_in_q, addr_in_d;
  logic [DataWidth-1:0] reg_in_q, reg_in_d;
  logic [NumRegs-1:0]   pending_q, pending_d;

  assign ld_req    = '{addr: wb.ld_addr, data: wb.ld_data};
  assign fifo_push = wb.ld_valid && !fifo_full;
  assign fifo_pop  = !wb.alu_valid && !fifo_empty;

  wb_load_fifo #(
    .Depth (LoadQDepth)
  ) u_load_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (ld_req),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // The ALU is never back-pressured, so it always wins; the FIFO head simply waits.
  always_comb begin
    reg_w_en_d = 1'b0;
    addr_in_d  = addr_in_q;
    reg_in_d   = reg_in_q;
    if (wb.alu_valid) begin
      reg_w_en_d = 1'b1;
      addr_in_d  = wb.alu_addr;
      reg_in_d   = wb.alu_data;
    end else if (!fifo_empty) begin
      reg_w_en_d = 1'b1;
      addr_in_d  = fifo_head.addr;
      reg_in_d   = fifo_head.data;
    end
  end

  // A register being written this cycle is still pending, so a stall blocks any same-index set.
  always_comb begin
    issue_stall = wb.issue_valid && pending_q[wb.issue_addr];
    pending_d   = pending_q;
    if (reg_w_en_q) begin
      pending_d[addr_in_q] = 1'b0;
    end
    if (wb.issue_valid && !issue_stall) begin
      pending_d[wb.issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_w_en_q <= 1'b0;
      addr_in_q  <= '0;
      reg_in_q   <= '0;
      pending_q  <= '0;
    end else begin
      reg_w_en_q <= reg_w_en_d;
      addr_in_q  <= addr_in_d;
      reg_in_q   <= reg_in_d;
      pending_q  <= pending_d;
    end
  end

  assign wb.issue_stall = issue_stall;
  assign wb.ld_ready    = !fifo_full;
  assign wb.reg_w_en    = reg_w_en_q;
  assign wb.addr_in     = addr_in_q;
  assign wb.reg_in      = reg_in_q;

`ifdef WB_FWD_EN
  // A hit means decode can take the value off the write port instead of waiting a cycle.
  assign wb.fwd_hit1  = reg_w_en_q && (addr_in_q == wb.chk_addr1);
  assign wb.fwd_hit2  = reg_w_en_q && (addr_in_q == wb.chk_addr2);
  assign wb.fwd_data1 = reg_in_q;
  assign wb.fwd_data2 = reg_in_q;
  assign wb.chk_busy1 = pending_q[wb.chk_addr1] && !wb.fwd_hit1;
  assign wb.chk_busy2 = pending_q[wb.chk_addr2] && !wb.fwd_hit2;
`else
  assign wb.chk_busy1 = pending_q[wb.chk_addr1];
  assign wb.chk_busy2 = pending_q[wb.chk_addr2];
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit with a queue-based reference model checked every cycle.
// Build with WB_FWD_EN defined to also exercise the forwarding outputs.
module tb_writeback_unit;
  import wb_pkg::*;

  localparam int LoadQDepth = 4;

  logic clk;
  logic rst_n;
  int   compared = 0;
  int   mismatched = 0;

  writeback_unit_if wbif ();

  writeback_unit #(
    .LoadQDepth (LoadQDepth)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wbif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what has been accepted, what is queued, what is reserved.
  bit          m_wen;
  logic [3:0]  m_addr;
  logic [15:0] m_data;
  bit   [15:0] m_pend;
  wb_req_t     m_q [$];
  wb_req_t     m_r;
  bit          m_acc;
  bit          m_issue_ok;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wen  = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_pend = '0;
      m_q.delete();
    end else begin
      m_acc      = wbif.ld_valid && (m_q.size() < LoadQDepth);
      m_issue_ok = wbif.issue_valid && !m_pend[wbif.issue_addr];
      if (m_wen) m_pend[m_addr] = 1'b0;
      if (m_issue_ok) m_pend[wbif.issue_addr] = 1'b1;
      if (wbif.alu_valid) begin
        m_wen  = 1'b1;
        m_addr = wbif.alu_addr;
        m_data = wbif.alu_data;
      end else if (m_q.size() > 0) begin
        m_r    = m_q.pop_front();
        m_wen  = 1'b1;
        m_addr = m_r.addr;
        m_data = m_r.data;
      end else begin
        m_wen = 1'b0;
      end
      if (m_wen) checkOutput("protocol_dest_pending", 32'(m_pend[m_addr]), 32'd1);
      if (m_acc) m_q.push_back('{addr: wbif.ld_addr, data: wbif.ld_data});
    end
  end

  // Every cycle: all outputs against the model, away from the active edge.
  always @(negedge clk) begin
    bit hit1, hit2;
`ifdef WB_FWD_EN
    hit1 = m_wen && (m_addr == wbif.chk_addr1);
    hit2 = m_wen && (m_addr == wbif.chk_addr2);
    checkOutput("fwd_hit1", 32'(wbif.fwd_hit1), 32'(hit1));
    checkOutput("fwd_hit2", 32'(wbif.fwd_hit2), 32'(hit2));
    checkOutput("fwd_data1", 32'(wbif.fwd_data1), 32'(m_data));
`else
    hit1 = 1'b0;
    hit2 = 1'b0;
`endif
    checkOutput("reg_w_en", 32'(wbif.reg_w_en), 32'(m_wen));
    checkOutput("addr_in", 32'(wbif.addr_in), 32'(m_addr));
    checkOutput("reg_in", 32'(wbif.reg_in), 32'(m_data));
    checkOutput("ld_ready", 32'(wbif.ld_ready), 32'(m_q.size() < LoadQDepth));
    checkOutput("issue_stall", 32'(wbif.issue_stall), 32'(wbif.issue_valid && m_pend[wbif.issue_addr]));
    checkOutput("chk_busy1", 32'(wbif.chk_busy1), 32'(m_pend[wbif.chk_addr1] && !hit1));
    checkOutput("chk_busy2", 32'(wbif.chk_busy2), 32'(m_pend[wbif.chk_addr2] && !hit2));
  end

  task automatic driveInputs(input logic iv, input logic [3:0] ia, input logic av, input logic [3:0] aa,
                             input logic [15:0] ad, input logic lv, input logic [3:0] la,
                             input logic [15:0] ldd, input logic [3:0] c1, input logic [3:0] c2);
    wbif.issue_valid = iv;
    wbif.issue_addr  = ia;
    wbif.alu_valid   = av;
    wbif.alu_addr    = aa;
    wbif.alu_data    = ad;
    wbif.ld_valid    = lv;
    wbif.ld_addr     = la;
    wbif.ld_data     = ldd;
    wbif.chk_addr1   = c1;
    wbif.chk_addr2   = c2;
  endtask

  // One cycle of stimulus; returns with outputs settled for that cycle.
  task automatic applyStimulus(input logic iv, input logic [3:0] ia, input logic av, input logic [3:0] aa,
                               input logic [15:0] ad, input logic lv, input logic [3:0] la,
                               input logic [15:0] ldd, input logic [3:0] c1, input logic [3:0] c2);
    @(posedge clk);
    #1;
    driveInputs(iv, ia, av, aa, ad, lv, la, ldd, c1, c2);
    #1;
  endtask

  task automatic issueReg(input logic [3:0] r);
    applyStimulus(1'b1, r, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, r, 4'd0);
  endtask

  task automatic idleCycle(input logic [3:0] c1);
    applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, c1, 4'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] lds [5];
    logic [3:0] li;
    lds = '{4'd1, 4'd2, 4'd4, 4'd6, 4'd7};

    driveInputs(1'b0, 4'd0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 4'd0, 4'd0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_reg_w_en", 32'(wbif.reg_w_en), 32'd0);
    checkOutput("reset_addr_in", 32'(wbif.addr_in), 32'd0);
    checkOutput("reset_reg_in", 32'(wbif.reg_in), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reserve r3, ALU writes it one cycle later.
    issueReg(4'd3);
    checkOutput("r3_issue_stall", 32'(wbif.issue_stall), 32'd0);
    checkOutput("ready_after_reset", 32'(wbif.ld_ready), 32'd1);
    applyStimulus(1'b0, 4'd0, 1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'd0, 4'd3, 4'd0);
    checkOutput("r3_busy_pending", 32'(wbif.chk_busy1), 32'd1);
    checkOutput("r3_not_written_yet", 32'(wbif.reg_w_en), 32'd0);
    idleCycle(4'd3);
    checkOutput("r3_wen", 32'(wbif.reg_w_en), 32'd1);
    checkOutput("r3_addr", 32'(wbif.addr_in), 32'd3);
    checkOutput("r3_data", 32'(wbif.reg_in), 32'h1234);
`ifdef WB_FWD_EN
    checkOutput("r3_busy_fwd_masked", 32'(wbif.chk_busy1), 32'd0);
`else
    checkOutput("r3_busy_on_port", 32'(wbif.chk_busy1), 32'd1);
`endif
    idleCycle(4'd3);
    checkOutput("r3_wen_one_cycle", 32'(wbif.reg_w_en), 32'd0);
    checkOutput("r3_busy_cleared", 32'(wbif.chk_busy1), 32'd0);
    checkOutput("idle_addr_hold", 32'(wbif.addr_in), 32'd3);

    // WAW on r5: second reservation refused until the write edge has passed.
    issueReg(4'd5);
    checkOutput("r5_first_stall", 32'(wbif.issue_stall), 32'd0);
    issueReg(4'd5);
    checkOutput("r5_second_stall", 32'(wbif.issue_stall), 32'd1);
    applyStimulus(1'b1, 4'd5, 1'b1, 4'd5, 16'h0055, 1'b0, 4'd0, 16'd0, 4'd5, 4'd0);
    checkOutput("r5_stall_alu_cycle", 32'(wbif.issue_stall), 32'd1);
    issueReg(4'd5);
    checkOutput("r5_stall_on_port", 32'(wbif.issue_stall), 32'd1);
    idleCycle(4'd5);
    checkOutput("r5_busy_cleared", 32'(wbif.chk_busy1), 32'd0);

    // ALU busy 6 cycles while five loads arrive; FIFO fills, then drains in order.
    for (int r = 0; r < 5; r++) issueReg(lds[r]);
    for (int r = 10; r < 16; r++) issueReg(4'(r));
    for (int c = 0; c < 8; c++) begin
      li = (c < 4) ? lds[c] : lds[4];
      applyStimulus(1'b0, 4'd0, c < 6, 4'(10 + c), 16'hC000 + 16'(c), 1'b1, li, 16'hA000 + 16'(li), 4'd1, 4'd7);
      if (c == 4) checkOutput("fifo_full_ready", 32'(wbif.ld_ready), 32'd0);
      if (c == 5) checkOutput("alu_r14_addr", 32'(wbif.addr_in), 32'd14);
      if (c == 7) begin
        checkOutput("first_load_addr", 32'(wbif.addr_in), 32'd1);
        checkOutput("first_load_data", 32'(wbif.reg_in), 32'hA001);
        checkOutput("ready_after_pop", 32'(wbif.ld_ready), 32'd1);
      end
    end
    for (int i = 0; i < 5; i++) begin
      idleCycle(4'd7);
      if (i == 0) checkOutput("second_load_addr", 32'(wbif.addr_in), 32'd2);
      if (i == 3) checkOutput("held_load_r7_data", 32'(wbif.reg_in), 32'hA007);
    end

    // ALU r8 and FIFO head r9 in the same cycle.
    issueReg(4'd8);
    issueReg(4'd9);
    applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd9, 16'h9999, 4'd8, 4'd9);
    applyStimulus(1'b0, 4'd0, 1'b1, 4'd8, 16'h8888, 1'b0, 4'd0, 16'd0, 4'd8, 4'd9);
    idleCycle(4'd8);
    checkOutput("alu_wins_addr", 32'(wbif.addr_in), 32'd8);
    checkOutput("alu_wins_data", 32'(wbif.reg_in), 32'h8888);
    idleCycle(4'd9);
    checkOutput("head_next_addr", 32'(wbif.addr_in), 32'd9);
    checkOutput("head_next_data", 32'(wbif.reg_in), 32'h9999);
    idleCycle(4'd9);

    // Reset with three loads queued and r1 pending.
    issueReg(4'd1);
    issueReg(4'd2);
    issueReg(4'd4);
    for (int r = 12; r < 15; r++) issueReg(4'(r));
    applyStimulus(1'b0, 4'd0, 1'b1, 4'd12, 16'hC012, 1'b1, 4'd1, 16'hA101, 4'd1, 4'd2);
    applyStimulus(1'b0, 4'd0, 1'b1, 4'd13, 16'hC013, 1'b1, 4'd2, 16'hA102, 4'd1, 4'd2);
    applyStimulus(1'b0, 4'd0, 1'b1, 4'd14, 16'hC014, 1'b1, 4'd4, 16'hA104, 4'd1, 4'd2);
    @(posedge clk);
    #2;
    checkOutput("pre_reset_addr", 32'(wbif.addr_in), 32'd14);
    checkOutput("pre_reset_busy_r1", 32'(wbif.chk_busy1), 32'd1);
    driveInputs(1'b0, 4'd0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 4'd1, 4'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_wen", 32'(wbif.reg_w_en), 32'd0);
    checkOutput("midreset_addr", 32'(wbif.addr_in), 32'd0);
    checkOutput("midreset_data", 32'(wbif.reg_in), 32'd0);
    checkOutput("midreset_busy_r1", 32'(wbif.chk_busy1), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) idleCycle(4'd1);
    checkOutput("after_reset_no_write", 32'(wbif.reg_w_en), 32'd0);
    checkOutput("after_reset_ready", 32'(wbif.ld_ready), 32'd1);
    checkOutput("after_reset_busy_r1", 32'(wbif.chk_busy1), 32'd0);

    // r10 = BEEF on the write port while decode checks r10.
    issueReg(4'd10);
    applyStimulus(1'b0, 4'd0, 1'b1, 4'd10, 16'hBEEF, 1'b0, 4'd0, 16'd0, 4'd10, 4'd0);
    idleCycle(4'd10);
    checkOutput("r10_data_on_port", 32'(wbif.reg_in), 32'hBEEF);
`ifdef WB_FWD_EN
    checkOutput("fwd_hit1_r10", 32'(wbif.fwd_hit1), 32'd1);
    checkOutput("fwd_data1_r10", 32'(wbif.fwd_data1), 32'hBEEF);
    checkOutput("fwd_busy1_r10", 32'(wbif.chk_busy1), 32'd0);
`else
    checkOutput("busy1_r10_on_port", 32'(wbif.chk_busy1), 32'd1);
`endif
    idleCycle(4'd10);
    idleCycle(4'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
